// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller: 16x sample-enable divider, receiver rdy/rdy_clr handshake,
// show-ahead byte FIFO with overflow flag. Optional idle timeout under UART_RX_TIMEOUT_EN.
module uart_rx_ctrl #(
  parameter int unsigned CLK_HZ        = 50000000,
  parameter int unsigned BAUD          = 115200,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned TIMEOUT_CHARS = 4
) (
  input  logic                          clk_50m,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          flush,
  output logic                          clken,
  output logic                          rx_en,
  input  logic                          rx_rdy,
  input  logic [7:0]                    rx_data,
  output logic                          rx_rdy_clr,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic                          timeout
);

  localparam int unsigned DIV = CLK_HZ / (BAUD * 16);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LW  = AW + 1;
  localparam logic [15:0]   DIV_LAST = 16'(DIV - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          rx_en_q, rx_rdy_clr_q;
  logic [15:0]   div_q, div_d;
  logic          clken_q, clken_d;
  logic          push, pop, full, wr_en, drop;
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    mem [FIFO_DEPTH];

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: if (enable) state_d = S_RUN;
      S_RUN: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (rx_rdy) begin
          state_d = S_ACK;
          push    = 1'b1;
        end
      end
      S_ACK:   state_d = enable ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Divider gated on the next state so disable stops clken on the very next edge.
  always_comb begin
    div_d   = '0;
    clken_d = 1'b0;
    if (state_d != S_IDLE) begin
      if (div_q == DIV_LAST) clken_d = 1'b1;
      else                   div_d   = div_q + 16'd1;
    end
  end

  assign full  = (level_q == LVL_FULL);
  assign pop   = m_valid & m_ready;
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_comb begin
    level_d = level_q;
    if (flush) begin
      level_d = '0;
    end else begin
      case ({wr_en, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    if (drop && !flush)    overflow_d = 1'b1;
    else if (overflow_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rx_en_q      <= 1'b1;
      rx_rdy_clr_q <= 1'b0;
      div_q        <= '0;
      clken_q      <= 1'b0;
      wr_q         <= '0;
      rd_q         <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_en_q      <= (state_d == S_IDLE);
      rx_rdy_clr_q <= (state_d == S_ACK);
      div_q        <= div_d;
      clken_q      <= clken_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      if (flush) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (wr_en) wr_q <= wr_q + AW'(1);
        if (pop)   rd_q <= rd_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk_50m) begin
    if (wr_en && !flush) mem[wr_q] <= rx_data;
  end

  assign clken      = clken_q;
  assign rx_en      = rx_en_q;
  assign rx_rdy_clr = rx_rdy_clr_q;
  assign m_data     = mem[rd_q];
  assign m_valid    = (level_q != '0);
  assign fifo_level = level_q;
  assign overflow   = overflow_q;

`ifdef UART_RX_TIMEOUT_EN
  localparam int unsigned TO_LIMIT = TIMEOUT_CHARS * 160;
  localparam int unsigned TW       = $clog2(TO_LIMIT + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TO_LIMIT);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_q, timeout_d;

  // Counted on clken_d so the flag rises on the same edge as the qualifying pulse.
  always_comb begin
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q;
    if (push || pop || flush || level_q == '0) begin
      to_cnt_d  = '0;
      timeout_d = 1'b0;
    end else if (clken_d && to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + TW'(1);
      if (to_cnt_d == TO_MAX) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: divider, handshake, FIFO order/overflow/flush, reset abort, timeout.
module tb_uart_rx_ctrl;

  logic       clk_50m = 1'b0;
  logic       rst_n, enable, flush, rx_rdy, m_ready, overflow_clr;
  logic [7:0] rx_data;
  logic       clken, rx_en, rx_rdy_clr, m_valid, overflow, timeout;
  logic [7:0] m_data;
  logic [3:0] fifo_level;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

`ifdef UART_RX_TIMEOUT_EN
  localparam logic TO_EXP = 1'b1;
`else
  localparam logic TO_EXP = 1'b0;
`endif

  uart_rx_ctrl #(
    .CLK_HZ(50000000), .BAUD(115200), .FIFO_DEPTH(8), .TIMEOUT_CHARS(4)
  ) dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .enable(enable), .flush(flush),
    .clken(clken), .rx_en(rx_en), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .rx_rdy_clr(rx_rdy_clr), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .fifo_level(fifo_level), .overflow(overflow), .overflow_clr(overflow_clr),
    .timeout(timeout)
  );

  always #10 clk_50m = ~clk_50m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_rdy = 1'b1; rx_data = b;
    @(negedge clk_50m);
    rx_rdy = 1'b0;
    @(negedge clk_50m);
  endtask

  initial begin
    int n, highs, pulses, cyc;
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; rx_rdy = 1'b0;
    m_ready = 1'b0; overflow_clr = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk_50m);
    chk("rst_clken", clken, 0);
    chk("rst_rx_en", rx_en, 1);
    chk("rst_clr", rx_rdy_clr, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_timeout", timeout, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_50m);

    // 1: divider and enable
    enable = 1'b1;
    n = 0;
    while (!clken && n < 100) begin @(negedge clk_50m); n++; end
    chk("clken_first", n, 27);
    chk("rx_en_run", rx_en, 0);
    @(negedge clk_50m);
    chk("clken_width", clken, 0);
    n = 1;
    while (!clken && n < 100) begin @(negedge clk_50m); n++; end
    chk("clken_period", n, 27);
    enable = 1'b0;
    @(negedge clk_50m);
    chk("rx_en_idle", rx_en, 1);
    highs = 0;
    repeat (60) begin
      if (clken) highs++;
      @(negedge clk_50m);
    end
    chk("clken_idle", highs, 0);
    enable = 1'b1;
    @(negedge clk_50m);

    // 2: single handshake
    rx_rdy = 1'b1; rx_data = 8'hA5;
    chk("clr_before", rx_rdy_clr, 0);
    @(negedge clk_50m);
    chk("clr_pulse", rx_rdy_clr, 1);
    chk("a5_valid", m_valid, 1);
    chk("a5_data", m_data, 8'hA5);
    chk("a5_level", fifo_level, 1);
    rx_rdy = 1'b0;
    @(negedge clk_50m);
    chk("clr_end", rx_rdy_clr, 0);
    chk("a5_level2", fifo_level, 1);
    m_ready = 1'b1;
    @(negedge clk_50m);
    m_ready = 1'b0;
    chk("pop_level", fifo_level, 0);
    chk("pop_valid", m_valid, 0);

    // 3: overflow and drain order
    for (int i = 1; i <= 9; i++) push_byte(8'(i));
    chk("full_level", fifo_level, 8);
    chk("ovf_set", overflow, 1);
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_data", m_data, i);
      @(negedge clk_50m);
    end
    m_ready = 1'b0;
    chk("drain_level", fifo_level, 0);
    overflow_clr = 1'b1;
    @(negedge clk_50m);
    overflow_clr = 1'b0;
    chk("ovf_clr", overflow, 0);
    for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
    rx_rdy = 1'b1; rx_data = 8'h99; overflow_clr = 1'b1;
    @(negedge clk_50m);
    rx_rdy = 1'b0; overflow_clr = 1'b0;
    chk("ovf_set_wins", overflow, 1);
    @(negedge clk_50m);
    overflow_clr = 1'b1;
    @(negedge clk_50m);
    overflow_clr = 1'b0;
    chk("ovf_clr2", overflow, 0);

    // 4: push+pop at full, then flush with push
    rx_rdy = 1'b1; rx_data = 8'hEE; m_ready = 1'b1;
    @(negedge clk_50m);
    rx_rdy = 1'b0; m_ready = 1'b0;
    chk("pp_level", fifo_level, 8);
    chk("pp_ovf", overflow, 0);
    chk("pp_head", m_data, 8'h11);
    @(negedge clk_50m);
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("pp_drain", m_data, (i < 7) ? 32'h11 + 32'(i) : 32'hEE);
      @(negedge clk_50m);
    end
    m_ready = 1'b0;
    chk("pp_empty", fifo_level, 0);
    for (int i = 0; i < 8; i++) push_byte(8'h20 + 8'(i));
    rx_rdy = 1'b1; rx_data = 8'h55; flush = 1'b1;
    @(negedge clk_50m);
    rx_rdy = 1'b0; flush = 1'b0;
    chk("flush_level", fifo_level, 0);
    chk("flush_valid", m_valid, 0);
    chk("flush_ovf", overflow, 0);
    @(negedge clk_50m);
    push_byte(8'h66);
    chk("post_flush_head", m_data, 8'h66);
    chk("post_flush_level", fifo_level, 1);

    // 5: reset during ACK
    rx_rdy = 1'b1; rx_data = 8'h77;
    @(negedge clk_50m);
    chk("ack_clr", rx_rdy_clr, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_clr", rx_rdy_clr, 0);
    chk("arst_rx_en", rx_en, 1);
    chk("arst_level", fifo_level, 0);
    rx_rdy = 1'b0;
    @(negedge clk_50m);
    rst_n = 1'b1;
    n = 0;
    while (!clken && n < 100) begin @(negedge clk_50m); n++; end
    chk("rel_clken", n, 27);
    chk("rel_rx_en", rx_en, 0);

    // 6: idle timeout
    rx_rdy = 1'b1; rx_data = 8'h42;
    @(negedge clk_50m);
    rx_rdy = 1'b0;
    pulses = 0; cyc = 0;
    while (pulses < 640 && cyc < 20000) begin
      if (clken) begin
        pulses++;
        if (pulses == 639) chk("timeout_639", timeout, 0);
      end
      if (pulses < 640) begin @(negedge clk_50m); cyc++; end
    end
    chk("timeout_pulses", pulses, 640);
    chk("timeout_640", timeout, TO_EXP);
    m_ready = 1'b1;
    @(negedge clk_50m);
    m_ready = 1'b0;
    chk("timeout_pop", timeout, 0);
    chk("timeout_level", fifo_level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
